// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared 16-bit combinational ALU.
// Holds registered operands for a fixed execute window, then returns the result over a response handshake.
module alu_arbiter #(
   parameter int unsigned EXEC_CYCLES = 1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req0_valid,
   input  logic [15:0] i_req0_a,
   input  logic [15:0] i_req0_b,
   input  logic [4:0]  i_req0_code,
   output logic        o_req0_ready,
   input  logic        i_req1_valid,
   input  logic [15:0] i_req1_a,
   input  logic [15:0] i_req1_b,
   input  logic [4:0]  i_req1_code,
   output logic        o_req1_ready,
   output logic [15:0] o_alu_a,
   output logic [15:0] o_alu_b,
   output logic [4:0]  o_alu_code,
   input  logic [15:0] i_alu_c,
   input  logic        i_alu_overflow,
   output logic        o_resp_valid,
   output logic        o_resp_id,
   output logic [15:0] o_resp_data,
   output logic        o_resp_overflow,
   input  logic        i_resp_ready,
   output logic        o_busy
);

   localparam int unsigned DW = 16;
   localparam int unsigned CODE_W = 5;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

   state_t            r_state;
   state_t            w_state_nx;
   logic              r_last_grant;
   logic [CNT_W-1:0]  r_exec_cnt;
   logic [DW-1:0]     r_alu_a;
   logic [DW-1:0]     r_alu_b;
   logic [CODE_W-1:0] r_alu_code;
   logic              r_resp_valid;
   logic              r_resp_id;
   logic [DW-1:0]     r_resp_data;
   logic              r_resp_overflow;
   logic              r_busy;
   logic              w_grant0;
   logic              w_grant1;
   logic              w_capture;

   // Next state and grant; requester 0 wins a tie only when requester 1 was served last.
   always_comb begin
      w_state_nx = r_state;
      w_grant0   = 1'b0;
      w_grant1   = 1'b0;
      w_capture  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_req0_valid && (!i_req1_valid || r_last_grant)) begin
               w_grant0 = 1'b1;
            end else if (i_req1_valid) begin
               w_grant1 = 1'b1;
            end
            if (i_req0_valid || i_req1_valid) begin
               w_state_nx = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (r_exec_cnt == CNT_W'(0)) begin
               w_capture  = 1'b1;
               w_state_nx = ST_RESP;
            end
         end
         ST_RESP: begin
            if (i_resp_ready) begin
               w_state_nx = ST_IDLE;
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state         <= ST_IDLE;
         r_last_grant    <= 1'b1;
         r_exec_cnt      <= CNT_W'(0);
         r_alu_a         <= DW'(0);
         r_alu_b         <= DW'(0);
         r_alu_code      <= CODE_W'(0);
         r_resp_valid    <= 1'b0;
         r_resp_id       <= 1'b0;
         r_resp_data     <= DW'(0);
         r_resp_overflow <= 1'b0;
         r_busy          <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_resp_valid <= (w_state_nx == ST_RESP);
         r_busy       <= (w_state_nx != ST_IDLE);
         if (w_grant0 || w_grant1) begin
            r_alu_a      <= w_grant1 ? i_req1_a    : i_req0_a;
            r_alu_b      <= w_grant1 ? i_req1_b    : i_req0_b;
            r_alu_code   <= w_grant1 ? i_req1_code : i_req0_code;
            r_resp_id    <= w_grant1;
            r_last_grant <= w_grant1;
            r_exec_cnt   <= CNT_W'(EXEC_CYCLES - 1);
         end else if (r_state == ST_EXEC && r_exec_cnt != CNT_W'(0)) begin
            r_exec_cnt <= r_exec_cnt - CNT_W'(1);
         end
         if (w_capture) begin
            r_resp_data     <= i_alu_c;
            r_resp_overflow <= i_alu_overflow;
         end
      end
   end

   assign o_req0_ready    = w_grant0;
   assign o_req1_ready    = w_grant1;
   assign o_alu_a         = r_alu_a;
   assign o_alu_b         = r_alu_b;
   assign o_alu_code      = r_alu_code;
   assign o_resp_valid    = r_resp_valid;
   assign o_resp_id       = r_resp_id;
   assign o_resp_data     = r_resp_data;
   assign o_resp_overflow = r_resp_overflow;
   assign o_busy          = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with a 1-cycle execute window, one with 3 cycles.
// Both use an adder stub as the ALU.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        v0 = 1'b0, v1 = 1'b0, v0_3 = 1'b0;
   logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic [4:0]  c0 = '0, c1 = '0;
   logic        resp_ready = 1'b0;

   logic        rdy0, rdy1, rv, rid, rov, busy;
   logic [15:0] alu_a, alu_b, alu_c, rdata;
   logic [4:0]  alu_code;
   logic        alu_ov;

   logic        rdy0_3, rdy1_3, rv_3, rid_3, rov_3, busy_3;
   logic [15:0] alu_a_3, alu_b_3, alu_c_3, rdata_3;
   logic [4:0]  alu_code_3;
   logic        alu_ov_3;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   assign alu_c    = alu_a + alu_b;
   assign alu_ov   = (alu_a[15] == alu_b[15]) && (alu_c[15] != alu_a[15]);
   assign alu_c_3  = alu_a_3 + alu_b_3;
   assign alu_ov_3 = (alu_a_3[15] == alu_b_3[15]) && (alu_c_3[15] != alu_a_3[15]);

   alu_arbiter #(.EXEC_CYCLES(1)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_req0_valid(v0), .i_req0_a(a0), .i_req0_b(b0), .i_req0_code(c0), .o_req0_ready(rdy0),
      .i_req1_valid(v1), .i_req1_a(a1), .i_req1_b(b1), .i_req1_code(c1), .o_req1_ready(rdy1),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_code(alu_code),
      .i_alu_c(alu_c), .i_alu_overflow(alu_ov),
      .o_resp_valid(rv), .o_resp_id(rid), .o_resp_data(rdata), .o_resp_overflow(rov),
      .i_resp_ready(resp_ready), .o_busy(busy)
   );

   alu_arbiter #(.EXEC_CYCLES(3)) dut3 (
      .i_clk(clk), .i_reset(reset),
      .i_req0_valid(v0_3), .i_req0_a(a0), .i_req0_b(b0), .i_req0_code(c0), .o_req0_ready(rdy0_3),
      .i_req1_valid(1'b0), .i_req1_a(a1), .i_req1_b(b1), .i_req1_code(c1), .o_req1_ready(rdy1_3),
      .o_alu_a(alu_a_3), .o_alu_b(alu_b_3), .o_alu_code(alu_code_3),
      .i_alu_c(alu_c_3), .i_alu_overflow(alu_ov_3),
      .o_resp_valid(rv_3), .o_resp_id(rid_3), .o_resp_data(rdata_3), .o_resp_overflow(rov_3),
      .i_resp_ready(resp_ready), .o_busy(busy_3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " alu_a"},    32'(alu_a), 32'h0);
      chk({tag, " alu_b"},    32'(alu_b), 32'h0);
      chk({tag, " alu_code"}, 32'(alu_code), 32'h0);
      chk({tag, " resp_valid"}, 32'(rv), 32'h0);
      chk({tag, " resp_id"},  32'(rid), 32'h0);
      chk({tag, " resp_data"}, 32'(rdata), 32'h0);
      chk({tag, " resp_ovf"}, 32'(rov), 32'h0);
      chk({tag, " busy"},     32'(busy), 32'h0);
      chk({tag, " ready0"},   32'(rdy0), 32'h0);
      chk({tag, " ready1"},   32'(rdy1), 32'h0);
   endtask

   initial begin
      // Reset state
      tick(); tick();
      reset = 1'b0;
      chk_reset_vals("reset");

      // Single request, EXEC_CYCLES=1
      v0 = 1'b1; a0 = 16'd58; b0 = 16'd555; c0 = 5'b01000;
      #1;
      chk("single c0 ready0", 32'(rdy0), 32'h1);
      chk("single c0 ready1", 32'(rdy1), 32'h0);
      tick(); v0 = 1'b0;
      chk("single c1 alu_a", 32'(alu_a), 32'd58);
      chk("single c1 alu_b", 32'(alu_b), 32'd555);
      chk("single c1 alu_code", 32'(alu_code), 32'h08);
      chk("single c1 busy", 32'(busy), 32'h1);
      chk("single c1 resp_valid", 32'(rv), 32'h0);
      tick();
      chk("single c2 resp_valid", 32'(rv), 32'h1);
      chk("single c2 resp_data", 32'(rdata), 32'd613);
      chk("single c2 resp_id", 32'(rid), 32'h0);
      chk("single c2 resp_ovf", 32'(rov), 32'h0);
      resp_ready = 1'b1;
      tick();
      chk("single c3 busy", 32'(busy), 32'h0);
      chk("single c3 resp_valid", 32'(rv), 32'h0);

      // Simultaneous requests after reset
      reset = 1'b1; tick(); reset = 1'b0;
      v0 = 1'b1; a0 = 16'd1; b0 = 16'd2;
      v1 = 1'b1; a1 = 16'd3; b1 = 16'd4;
      #1;
      chk("tie1 ready0", 32'(rdy0), 32'h1);
      chk("tie1 ready1", 32'(rdy1), 32'h0);
      tick(); v0 = 1'b0;
      chk("tie1 exec ready1", 32'(rdy1), 32'h0);
      chk("tie1 exec alu_a", 32'(alu_a), 32'd1);
      tick();
      chk("tie1 resp_data", 32'(rdata), 32'd3);
      chk("tie1 resp_id", 32'(rid), 32'h0);
      tick();
      chk("tie1 next ready1", 32'(rdy1), 32'h1);
      tick(); v1 = 1'b0;
      chk("tie1 exec2 alu_a", 32'(alu_a), 32'd3);
      tick();
      chk("tie1 resp2 valid", 32'(rv), 32'h1);
      chk("tie1 resp2 data", 32'(rdata), 32'd7);
      chk("tie1 resp2 id", 32'(rid), 32'h1);
      tick();
      v0 = 1'b1; a0 = 16'd10; b0 = 16'd20;
      v1 = 1'b1; a1 = 16'd30; b1 = 16'd40;
      #1;
      chk("tie2 ready0", 32'(rdy0), 32'h1);
      chk("tie2 ready1", 32'(rdy1), 32'h0);

      // Backpressure with req1 pending
      tick(); v0 = 1'b0; resp_ready = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp resp_valid", 32'(rv), 32'h1);
         chk("bp resp_data", 32'(rdata), 32'd30);
         chk("bp ready0", 32'(rdy0), 32'h0);
         chk("bp ready1", 32'(rdy1), 32'h0);
         tick();
      end
      resp_ready = 1'b1;
      #1;
      chk("bp release ready1", 32'(rdy1), 32'h0);
      chk("bp release data", 32'(rdata), 32'd30);
      tick();
      chk("bp accept ready1", 32'(rdy1), 32'h1);
      tick(); v1 = 1'b0;
      chk("bp exec alu_a", 32'(alu_a), 32'd30);
      tick();
      chk("bp resp data", 32'(rdata), 32'd70);
      chk("bp resp id", 32'(rid), 32'h1);
      tick();
      chk("bp idle busy", 32'(busy), 32'h0);

      // Overflow and latency, EXEC_CYCLES=3
      reset = 1'b1; tick(); reset = 1'b0;
      v0_3 = 1'b1; a0 = 16'h7FFF; b0 = 16'h0001; c0 = 5'd0;
      #1;
      chk("ovf accept ready0", 32'(rdy0_3), 32'h1);
      tick(); v0_3 = 1'b0;
      for (int k = 1; k < 4; k++) begin
         chk("ovf wait resp_valid", 32'(rv_3), 32'h0);
         chk("ovf wait busy", 32'(busy_3), 32'h1);
         tick();
      end
      chk("ovf resp_valid", 32'(rv_3), 32'h1);
      chk("ovf resp_data", 32'(rdata_3), 32'h8000);
      chk("ovf resp_ovf", 32'(rov_3), 32'h1);
      chk("ovf resp_id", 32'(rid_3), 32'h0);
      tick();

      // Reset mid-operation
      v0 = 1'b1; a0 = 16'd5; b0 = 16'd6; c0 = 5'd3;
      #1;
      chk("rst accept ready0", 32'(rdy0), 32'h1);
      tick(); v0 = 1'b0;
      chk("rst exec busy", 32'(busy), 32'h1);
      reset = 1'b1;
      tick(); reset = 1'b0;
      chk_reset_vals("midrst");
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("midrst no resp", 32'(rv), 32'h0);
      end
      v1 = 1'b1; a1 = 16'd100; b1 = 16'd200; c1 = 5'd1;
      #1;
      chk("post rst ready1", 32'(rdy1), 32'h1);
      tick(); v1 = 1'b0;
      tick();
      chk("post rst resp_valid", 32'(rv), 32'h1);
      chk("post rst resp_data", 32'(rdata), 32'd300);
      chk("post rst resp_id", 32'(rid), 32'h1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single 16-bit ALU datapath between two requesters. It accepts one operation at a time over a valid/ready handshake and drives the ALU operand and code inputs from registered copies. After a fixed execute window it captures the ALU result and overflow flag, then returns them to the winning requester through a response handshake with backpressure. It sits between the instruction-issue logic and the ALU; the ALU itself stays purely combinational.

## Interface

- EXEC_CYCLES, 1: cycles the operands are held on the ALU before the result is captured (1..15).
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_a, req0_b  in  16  requester 0 operands.
- req0_code  in  5  requester 0 ALU operation code.
- req0_ready  out  1  one-cycle accept pulse for requester 0.
- req1_valid, req1_a, req1_b, req1_code, req1_ready: same as requester 0, for requester 1.
- alu_a, alu_b  out  16  registered operands driven to the ALU.
- alu_code  out  5  registered operation code driven to the ALU.
- alu_c  in  16  ALU result, combinational from alu_a/alu_b/alu_code.
- alu_overflow  in  1  ALU overflow flag.
- resp_valid  out  1  result available.
- resp_id  out  1  requester that owns the result.
- resp_data  out  16  captured result.
- resp_overflow  out  1  captured overflow.
- resp_ready  in  1  consumer accepts the result.
- busy  out  1  high in any state other than IDLE.

## Operation

- States: IDLE, EXEC, RESP.
- **IDLE:**
  - If any reqN_valid is high, pick a winner and assert its reqN_ready combinationally in the same cycle.
  - On the clock edge, latch the winner's a/b/code into alu_a/alu_b/alu_code, record the winner in resp_id, load exec_cnt = EXEC_CYCLES-1, and go to EXEC.
  - If no request is valid, stay in IDLE.
- **Arbitration:**
  - If exactly one requester is valid, it wins.
  - If both are valid, the requester not recorded in last_grant wins.
  - last_grant updates on every accept.
  - last_grant resets to 1, so requester 0 wins the first tie.
- **EXEC:**
  - alu_a/alu_b/alu_code are held constant.
  - If exec_cnt == 0: capture alu_c into resp_data and alu_overflow into resp_overflow, then go to RESP.
  - Otherwise decrement exec_cnt.
- **RESP:**
  - resp_valid = 1.
  - If resp_ready is high, go to IDLE on the edge.
  - Otherwise hold resp_valid, resp_data, resp_overflow and resp_id unchanged.
- Only IDLE may assert a reqN_ready; at most one reqN_ready is high in any cycle.
- Requests arriving during EXEC or RESP wait; requesters must hold valid and payload stable until their ready pulse.
- alu_* outputs keep their last value outside EXEC; they are never cleared except by reset.
- No combinational path from resp_ready to any reqN_ready.

## Timing

- Reset values:
  - state = IDLE, last_grant = 1, exec_cnt = 0.
  - alu_a = alu_b = 0, alu_code = 0.
  - resp_valid = 0, resp_id = 0, resp_data = 0, resp_overflow = 0.
  - busy = 0, req0_ready = req1_ready = 0.
- Accept at cycle T (reqN_valid && reqN_ready) produces:
  - alu_* valid from T+1;
  - result capture at the end of cycle T+EXEC_CYCLES;
  - resp_valid high from T+EXEC_CYCLES+1.
- Responses are returned in acceptance order.
- resp_ready high in RESP cycle R gives IDLE at R+1. The earliest next accept is R+1, so back-to-back throughput is one operation per EXEC_CYCLES+2 cycles.
- resp_ready high outside RESP is ignored.
- Reset asserted in any state:
  - returns everything to reset values on the next edge;
  - discards the in-flight operation with no response;
  - clears the pending response.
- reset has priority over every other condition in the same cycle.

## Test plan

The bench ALU stub returns A+B with signed overflow.

- **Single request:** req0 with a=58, b=555, code=5'b01000, EXEC_CYCLES=1.
  - req0_ready pulses in cycle 0.
  - alu_a=58 and alu_b=555 from cycle 1.
  - resp_valid in cycle 2 with resp_data=613, resp_id=0, resp_overflow=0.
- **Simultaneous requests after reset:** req0 (a=1, b=2) and req1 (a=3, b=4), resp_ready held 1.
  - Responses in order: 3 with id 0, then 7 with id 1.
  - The next tie goes to requester 0.
- **Backpressure:** resp_ready low for 5 cycles in RESP.
  - resp_valid/resp_data stay stable.
  - No reqN_ready is asserted.
  - The pending req1 is accepted only in the cycle after resp_ready goes high.
- **Overflow and latency:** a=16'h7FFF, b=1, EXEC_CYCLES=3.
  - resp_data=16'h8000, resp_overflow=1.
  - resp_valid rises exactly 4 cycles after the accept cycle.
- **Reset mid-operation:** assert reset during EXEC.
  - Next cycle all outputs are at reset values.
  - No response is issued.
  - A new req1 is accepted normally afterwards.
